// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet L2 header parser.
package eth_parser_pkg;

    localparam int DATA_W = 64;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic        vlan_present;
        logic [2:0]  vlan_pcp;
        logic [11:0] vlan_id;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        truncated;
    } eth_metadata_t;

    typedef enum logic [1:0] {
        HDR0,
        HDR1,
        HDR2,
        PAYLOAD
    } parser_state_t;

    // Fill in the classification flags from the final EtherType.
    function automatic eth_metadata_t classify(input eth_metadata_t m);
        eth_metadata_t r;
        r         = m;
        r.is_ipv4 = (m.ethertype == ETH_TYPE_IPV4);
        r.is_ipv6 = (m.ethertype == ETH_TYPE_IPV6);
        r.is_arp  = (m.ethertype == ETH_TYPE_ARP);
        return r;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage AXI4-Stream register slice carrying data and last.
module axis_reg_slice #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         m_valid,
    input  logic         m_ready
);

    // Accept whenever the output register is empty or being drained; never during reset.
    assign s_ready = !rst && (!m_valid || m_ready);

    // Output register: load on accept, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) begin
                m_data <= s_data;
                m_last <= s_last;
            end
        end
    end

endmodule

// File: rtl/ethernet_frame_parser.sv
// Streaming L2 header parser: forwards beats through a register slice and
// publishes a metadata record once per frame.
//
// state   | meaning
// HDR0    | expecting beat 0 (dest MAC, top of src MAC)
// HDR1    | expecting beat 1 (rest of src MAC, first EtherType / TPID)
// HDR2    | expecting beat 2 of a tagged frame (inner EtherType)
// PAYLOAD | header done, forwarding until tlast
module ethernet_frame_parser
    import eth_parser_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output eth_metadata_t       m_axis_tuser,
    output logic                m_axis_tuser_valid
);

    parser_state_t state, state_nxt;
    logic          accept;
    logic          publish;
    eth_metadata_t rec;
    logic [15:0]   etype0;

    // Shadow copies of the partially parsed header of the frame in flight.
    logic [47:0]   sh_dest;
    logic [15:0]   sh_src_hi;
    logic [31:0]   sh_src_lo;
    logic [2:0]    sh_pcp;
    logic [11:0]   sh_vid;

    assign accept = s_axis_tvalid && s_axis_tready;
    assign etype0 = s_axis_tdata[31:16];

    axis_reg_slice #(.W(DATA_W)) u_slice (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_axis_tdata),
        .s_last  (s_axis_tlast),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (m_axis_tdata),
        .m_last  (m_axis_tlast),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HDR0;
        else     state <= state_nxt;
    end

    // Next state and the record to publish; fields not yet seen stay zero.
    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        rec       = '0;
        if (accept) begin
            case (state)
                HDR0: begin
                    rec.dest_mac = s_axis_tdata[63:16];
                    rec.src_mac  = {s_axis_tdata[15:0], 32'h0};
                    if (s_axis_tlast) begin
                        rec.truncated = 1'b1;
                        publish       = 1'b1;
                    end else begin
                        state_nxt = HDR1;
                    end
                end
                HDR1: begin
                    rec.dest_mac = sh_dest;
                    rec.src_mac  = {sh_src_hi, s_axis_tdata[63:32]};
                    if (etype0 != ETH_TYPE_VLAN) begin
                        rec.ethertype = etype0;
                        rec           = classify(rec);
                        publish       = 1'b1;
                        state_nxt     = s_axis_tlast ? HDR0 : PAYLOAD;
                    end else begin
                        rec.vlan_present = 1'b1;
                        rec.vlan_pcp     = s_axis_tdata[15:13];
                        rec.vlan_id      = s_axis_tdata[11:0];
                        if (s_axis_tlast) begin
                            rec.truncated = 1'b1;
                            publish       = 1'b1;
                            state_nxt     = HDR0;
                        end else begin
                            state_nxt = HDR2;
                        end
                    end
                end
                HDR2: begin
                    rec.dest_mac     = sh_dest;
                    rec.src_mac      = {sh_src_hi, sh_src_lo};
                    rec.vlan_present = 1'b1;
                    rec.vlan_pcp     = sh_pcp;
                    rec.vlan_id      = sh_vid;
                    rec.ethertype    = s_axis_tdata[63:48];
                    rec              = classify(rec);
                    publish          = 1'b1;
                    state_nxt        = s_axis_tlast ? HDR0 : PAYLOAD;
                end
                PAYLOAD: begin
                    if (s_axis_tlast) state_nxt = HDR0;
                end
                default: state_nxt = HDR0;
            endcase
        end
    end

    // Capture header fragments that are needed by a later beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_dest   <= '0;
            sh_src_hi <= '0;
            sh_src_lo <= '0;
            sh_pcp    <= '0;
            sh_vid    <= '0;
        end else if (accept) begin
            if (state == HDR0) begin
                sh_dest   <= s_axis_tdata[63:16];
                sh_src_hi <= s_axis_tdata[15:0];
            end
            if (state == HDR1) begin
                sh_src_lo <= s_axis_tdata[63:32];
                sh_pcp    <= s_axis_tdata[15:13];
                sh_vid    <= s_axis_tdata[11:0];
            end
        end
    end

    // Published record and its one-cycle strobe; the record holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tuser       <= '0;
            m_axis_tuser_valid <= 1'b0;
        end else begin
            m_axis_tuser_valid <= publish;
            if (publish) m_axis_tuser <= rec;
        end
    end

endmodule

// File: tb/tb_ethernet_frame_parser.sv
// Directed, table-driven bench for ethernet_frame_parser.
module tb_ethernet_frame_parser;
    import eth_parser_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [63:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    eth_metadata_t m_tuser;
    logic          m_tuser_valid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit bp_en = 1'b0;

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          c;
    } beat_t;

    typedef struct {
        logic [63:0]   beat[3];
        int            nbeats;
        int            cidx;
        eth_metadata_t exp;
        string         name;
    } vec_t;

    beat_t         in_q[$];
    beat_t         out_q[$];
    eth_metadata_t strobe_q[$];
    int            strobe_cyc_q[$];
    vec_t          vecs[6];

    logic          prev_stall = 1'b0;
    logic [63:0]   prev_d = '0;
    logic          prev_l = 1'b0;

    ethernet_frame_parser dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tdata       (s_tdata),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tready      (s_tready),
        .s_axis_tlast       (s_tlast),
        .m_axis_tdata       (m_tdata),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_tlast       (m_tlast),
        .m_axis_tuser       (m_tuser),
        .m_axis_tuser_valid (m_tuser_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random downstream backpressure while enabled.
    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: record handshakes and strobes, check hold while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                checks++;
                if (!(m_tvalid && m_tdata == prev_d && m_tlast == prev_l)) begin
                    failures++;
                    $display("FAIL stall_hold got=%h/%b/%b exp=%h/%b/1", m_tdata, m_tlast, m_tvalid, prev_d, prev_l);
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
            if (m_tvalid && m_tready) out_q.push_back('{m_tdata, m_tlast, cyc});
            if (m_tuser_valid) begin
                strobe_q.push_back(m_tuser);
                strobe_cyc_q.push_back(cyc);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic eth_metadata_t mk_meta(
        input logic [47:0] dest, input logic [47:0] src, input logic [15:0] et,
        input logic vp, input logic [2:0] pcp, input logic [11:0] vid,
        input logic v4, input logic v6, input logic arp, input logic tr);
        eth_metadata_t m;
        m.dest_mac = dest; m.src_mac = src; m.ethertype = et;
        m.vlan_present = vp; m.vlan_pcp = pcp; m.vlan_id = vid;
        m.is_ipv4 = v4; m.is_ipv6 = v6; m.is_arp = arp; m.truncated = tr;
        return m;
    endfunction

    task automatic chk(input string n, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        bit acc = 1'b0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (acc) begin
            in_q.push_back('{d, l, cyc});
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=no_accept exp=accept data=%h", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string n, input bit lat);
        beat_t a, b;
        chk({n, "_beat_count"}, 132'(out_q.size()), 132'(in_q.size()));
        while (in_q.size() > 0 && out_q.size() > 0) begin
            a = in_q.pop_front();
            b = out_q.pop_front();
            chk({n, "_beat"}, {b.l, b.d}, {a.l, a.d});
            if (lat) chk({n, "_latency"}, 132'(b.c), 132'(a.c));
        end
        in_q.delete();
        out_q.delete();
    endtask

    task automatic clear_strobes();
        strobe_q.delete();
        strobe_cyc_q.delete();
    endtask

    task automatic check_reset_outputs(input string n);
        chk({n, "_s_tready"}, 132'(s_tready), 132'(0));
        chk({n, "_m_tvalid"}, 132'(m_tvalid), 132'(0));
        chk({n, "_m_tlast"}, 132'(m_tlast), 132'(0));
        chk({n, "_m_tdata"}, 132'(m_tdata), 132'(0));
        chk({n, "_m_tuser"}, 132'(m_tuser), 132'(0));
        chk({n, "_m_tuser_valid"}, 132'(m_tuser_valid), 132'(0));
    endtask

    task automatic send_vec(input int k);
        for (int b = 0; b < vecs[k].nbeats; b++)
            send_beat(vecs[k].beat[b], b == vecs[k].nbeats - 1);
    endtask

    initial begin
        int comp_cyc;

        vecs[0] = '{'{64'hFFFFFFFFFFFF0011, 64'h2233445508000000, 64'h0000000000000000}, 3, 1,
                    mk_meta(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 0, 0, 12'h0, 1, 0, 0, 0), "ipv4"};
        vecs[1] = '{'{64'h0A0B0C0D0E0F1020, 64'h3040506081006064, 64'h86DD000000000000}, 3, 2,
                    mk_meta(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 1, 3, 12'h064, 0, 1, 0, 0), "vlan_ipv6"};
        vecs[2] = '{'{64'h112233445566AABB, 64'h0, 64'h0}, 1, 0,
                    mk_meta(48'h112233445566, 48'hAABB00000000, 16'h0000, 0, 0, 12'h0, 0, 0, 0, 1), "trunc_beat0"};
        vecs[3] = '{'{64'h001B213A4B5C0102, 64'h0304050608060001, 64'h0}, 2, 1,
                    mk_meta(48'h001B213A4B5C, 48'h010203040506, 16'h0806, 0, 0, 12'h0, 0, 0, 1, 0), "arp_short"};
        vecs[4] = '{'{64'hAAAAAAAAAAAABBBB, 64'hCCCCDDDD8100E00A, 64'h0}, 2, 1,
                    mk_meta(48'hAAAAAAAAAAAA, 48'hBBBBCCCCDDDD, 16'h0000, 1, 7, 12'h00A, 0, 0, 0, 1), "trunc_vlan"};
        vecs[5] = '{'{64'h0180C200000E0203, 64'h0405060788CC0000, 64'h1234567890ABCDEF}, 3, 1,
                    mk_meta(48'h0180C200000E, 48'h020304050607, 16'h88CC, 0, 0, 12'h0, 0, 0, 0, 0), "lldp"};

        // Reset state.
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        clear_strobes();

        // Table-driven frames with downstream always ready.
        for (int k = 0; k < 6; k++) begin
            in_q.delete();
            out_q.delete();
            send_vec(k);
            comp_cyc = in_q[vecs[k].cidx].c;
            idle(22);
            @(negedge clk);
            chk({vecs[k].name, "_strobes"}, 132'(strobe_q.size()), 132'(1));
            if (strobe_q.size() > 0) begin
                chk({vecs[k].name, "_meta"}, strobe_q[0], vecs[k].exp);
                chk({vecs[k].name, "_strobe_cycle"}, 132'(strobe_cyc_q[0]), 132'(comp_cyc));
            end
            chk({vecs[k].name, "_meta_hold"}, m_tuser, vecs[k].exp);
            check_stream(vecs[k].name, 1'b1);
            clear_strobes();
            @(posedge clk);
            #1;
        end

        // ARP frame under random backpressure.
        bp_en = 1'b1;
        send_beat(64'h0800270A0B0C5254, 1'b0);
        send_beat(64'h0012345608060001, 1'b0);
        send_beat(64'h0800060400010000, 1'b0);
        send_beat(64'hC0A80001DEADBEEF, 1'b1);
        bp_en = 1'b0;
        @(posedge clk);
        #2 m_tready = 1'b1;
        idle(5);
        @(negedge clk);
        chk("bp_strobes", 132'(strobe_q.size()), 132'(1));
        if (strobe_q.size() > 0)
            chk("bp_meta", strobe_q[0],
                mk_meta(48'h0800270A0B0C, 48'h525400123456, 16'h0806, 0, 0, 12'h0, 0, 0, 1, 0));
        check_stream("bp", 1'b0);
        clear_strobes();
        @(posedge clk);
        #1;

        // Back-to-back frames with consecutive strobes.
        send_vec(3);
        send_vec(2);
        idle(5);
        @(negedge clk);
        chk("b2b_strobes", 132'(strobe_q.size()), 132'(2));
        if (strobe_q.size() == 2) begin
            chk("b2b_meta_a", strobe_q[0], vecs[3].exp);
            chk("b2b_meta_b", strobe_q[1], vecs[2].exp);
            chk("b2b_strobe_gap", 132'(strobe_cyc_q[1]), 132'(strobe_cyc_q[0] + 1));
        end
        check_stream("b2b", 1'b1);
        clear_strobes();
        @(posedge clk);
        #1;

        // Reset in the middle of a tagged header.
        send_beat(vecs[1].beat[0], 1'b0);
        send_beat(vecs[1].beat[1], 1'b0);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);
        @(negedge clk);
        chk("midrst_no_strobe", 132'(strobe_q.size()), 132'(0));
        in_q.delete();
        out_q.delete();
        clear_strobes();
        @(posedge clk);
        #1;
        send_vec(1);
        idle(5);
        @(negedge clk);
        chk("post_rst_strobes", 132'(strobe_q.size()), 132'(1));
        if (strobe_q.size() > 0) chk("post_rst_meta", strobe_q[0], vecs[1].exp);
        check_stream("post_rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
